// File: rtl/cpu_pkg.sv
// Shared widths, operand types and the writeback-bypass match helper for the operand fetch path.
package cpu_pkg;

    localparam int AW = 5;
    localparam int SW = 16;
    localparam int VW = 128;
    localparam int NSRC = 3;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [SW-1:0] sdata_t;
    typedef logic [VW-1:0] vdata_t;

    typedef struct packed {
        logic      vec;
        logic      dst_we;
        reg_addr_t dst;
    } fetch_op_t;

    // True when this cycle's writeback lands in the same file and register being read.
    function automatic logic wb_hit(input logic wre, input logic wvec, input reg_addr_t wa,
                                    input logic vec, input reg_addr_t a);
        return wre && (wvec == vec) && (wa == a);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for one register file: one set port (issue), one clear port (writeback),
// three source lookups plus a destination lookup, with the same-cycle writeback treated as not busy.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int AW = cpu_pkg::AW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     set_en,
    input  logic [AW-1:0]            set_addr,
    input  logic                     clr_en,
    input  logic [AW-1:0]            clr_addr,
    input  logic [NSRC-1:0]          src_use,
    input  logic [NSRC-1:0][AW-1:0]  src_addr,
    input  logic                     dst_chk,
    input  logic [AW-1:0]            dst_addr,
    output logic                     hazard
);

    localparam int NREG = 2 ** AW;

    logic [NREG-1:0] busy;

    // Set is applied after clear so a register issued and retired on the same edge stays busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_addr] <= 1'b0;
            if (set_en) busy[set_addr] <= 1'b1;
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_use[i] && busy[src_addr[i]] && !(clr_en && clr_addr == src_addr[i]))
                hazard = 1'b1;
        end
        if (dst_chk && busy[dst_addr] && !(clr_en && clr_addr == dst_addr))
            hazard = 1'b1;
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: regfile read addressing, writeback bypass, RAW/WAW stall via per-file scoreboards,
// and a valid/ready output register toward execute.
module operand_fetch_stage
    import cpu_pkg::*;
#(
    parameter int AW = cpu_pkg::AW,
    parameter int SW = cpu_pkg::SW,
    parameter int VW = cpu_pkg::VW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_vec,
    input  logic [2:0]    in_src_use,
    input  logic [AW-1:0] in_a1,
    input  logic [AW-1:0] in_a2,
    input  logic [AW-1:0] in_a3,
    input  logic          in_dst_we,
    input  logic [AW-1:0] in_dst,
    output logic [AW-1:0] rf_a1,
    output logic [AW-1:0] rf_a2,
    output logic [AW-1:0] rf_a3,
    input  logic [SW-1:0] rd1_s,
    input  logic [SW-1:0] rd2_s,
    input  logic [SW-1:0] rd3_s,
    input  logic [VW-1:0] rd1_v,
    input  logic [VW-1:0] rd2_v,
    input  logic [VW-1:0] rd3_v,
    input  logic          wb_wre,
    input  logic          wb_vec,
    input  logic [AW-1:0] wb_a3,
    input  logic [SW-1:0] wb_wd3_s,
    input  logic [VW-1:0] wb_wd3_v,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_vec,
    output logic          out_dst_we,
    output logic [AW-1:0] out_dst,
    output logic [SW-1:0] out_op1_s,
    output logic [SW-1:0] out_op2_s,
    output logic [SW-1:0] out_op3_s,
    output logic [VW-1:0] out_op1_v,
    output logic [VW-1:0] out_op2_v,
    output logic [VW-1:0] out_op3_v,
    output logic [15:0]   stall_cycles
);

    logic [NSRC-1:0][AW-1:0] src_a;
    logic [NSRC-1:0][SW-1:0] rd_s, op_s_d, op_s_q;
    logic [NSRC-1:0][VW-1:0] rd_v, op_v_d, op_v_q;
    logic                    hazard_s, hazard_v, hazard, issue;
    fetch_op_t               op_q;

    assign src_a = {in_a3, in_a2, in_a1};
    assign rd_s  = {rd3_s, rd2_s, rd1_s};
    assign rd_v  = {rd3_v, rd2_v, rd1_v};
    assign rf_a1 = in_a1;
    assign rf_a2 = in_a2;
    assign rf_a3 = in_a3;

    // Each scoreboard only sees lookups and writebacks for its own file, which gives the file-match exemption.
    reg_scoreboard #(.AW(AW)) u_sb_s (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue && in_dst_we && !in_vec),
        .set_addr (in_dst),
        .clr_en   (wb_wre && !wb_vec),
        .clr_addr (wb_a3),
        .src_use  (in_vec ? 3'b000 : in_src_use),
        .src_addr (src_a),
        .dst_chk  (in_dst_we && !in_vec),
        .dst_addr (in_dst),
        .hazard   (hazard_s)
    );

    reg_scoreboard #(.AW(AW)) u_sb_v (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue && in_dst_we && in_vec),
        .set_addr (in_dst),
        .clr_en   (wb_wre && wb_vec),
        .clr_addr (wb_a3),
        .src_use  (in_vec ? in_src_use : 3'b000),
        .src_addr (src_a),
        .dst_chk  (in_dst_we && in_vec),
        .dst_addr (in_dst),
        .hazard   (hazard_v)
    );

    assign hazard   = hazard_s || hazard_v;
    assign in_ready = !hazard && (!out_valid || out_ready);
    assign issue    = in_valid && in_ready;

    for (genvar i = 0; i < NSRC; i++) begin : g_bypass
        logic hit;
        assign hit = wb_hit(wb_wre, wb_vec, wb_a3, in_vec, src_a[i]);
        assign op_s_d[i] = (!in_src_use[i] || in_vec)  ? '0 : (hit ? wb_wd3_s : rd_s[i]);
        assign op_v_d[i] = (!in_src_use[i] || !in_vec) ? '0 : (hit ? wb_wd3_v : rd_v[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            op_q      <= '0;
            op_s_q    <= '0;
            op_v_q    <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            op_q      <= '{vec: in_vec, dst_we: in_dst_we, dst: in_dst};
            op_s_q    <= op_s_d;
            op_v_q    <= op_v_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (in_valid && !in_ready && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end

    assign out_vec    = op_q.vec;
    assign out_dst_we = op_q.dst_we;
    assign out_dst    = op_q.dst;
    assign out_op1_s  = op_s_q[0];
    assign out_op2_s  = op_s_q[1];
    assign out_op3_s  = op_s_q[2];
    assign out_op1_v  = op_v_q[0];
    assign out_op2_v  = op_v_q[1];
    assign out_op3_v  = op_v_q[2];

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: expected operand bundles queued at issue, compared on handshake.
module tb_operand_fetch_stage;
    import cpu_pkg::*;

    typedef struct packed {
        logic                 vec;
        logic                 dst_we;
        logic [AW-1:0]        dst;
        logic [2:0][SW-1:0]   s;
        logic [2:0][VW-1:0]   v;
    } exp_t;

    logic          clk = 1'b0, reset = 1'b1;
    logic          in_valid, in_ready, in_vec, in_dst_we;
    logic [2:0]    in_src_use;
    logic [AW-1:0] in_a1, in_a2, in_a3, in_dst, rf_a1, rf_a2, rf_a3, wb_a3, out_dst;
    logic [SW-1:0] rd1_s, rd2_s, rd3_s, wb_wd3_s, out_op1_s, out_op2_s, out_op3_s;
    logic [VW-1:0] rd1_v, rd2_v, rd3_v, wb_wd3_v, out_op1_v, out_op2_v, out_op3_v;
    logic          wb_wre, wb_vec, out_valid, out_ready, out_vec, out_dst_we;
    logic [15:0]   stall_cycles;

    logic [SW-1:0] rf_s [32];
    logic [VW-1:0] rf_v [32];
    exp_t          q[$];
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign rd1_s = rf_s[rf_a1];
    assign rd2_s = rf_s[rf_a2];
    assign rd3_s = rf_s[rf_a3];
    assign rd1_v = rf_v[rf_a1];
    assign rd2_v = rf_v[rf_a2];
    assign rd3_v = rf_v[rf_a3];

    operand_fetch_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .in_src_use(in_src_use), .in_a1(in_a1), .in_a2(in_a2), .in_a3(in_a3),
        .in_dst_we(in_dst_we), .in_dst(in_dst), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3),
        .rd1_s(rd1_s), .rd2_s(rd2_s), .rd3_s(rd3_s), .rd1_v(rd1_v), .rd2_v(rd2_v), .rd3_v(rd3_v),
        .wb_wre(wb_wre), .wb_vec(wb_vec), .wb_a3(wb_a3), .wb_wd3_s(wb_wd3_s), .wb_wd3_v(wb_wd3_v),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_dst_we(out_dst_we),
        .out_dst(out_dst), .out_op1_s(out_op1_s), .out_op2_s(out_op2_s), .out_op3_s(out_op3_s),
        .out_op1_v(out_op1_v), .out_op2_v(out_op2_v), .out_op3_v(out_op3_v),
        .stall_cycles(stall_cycles)
    );

    // Handshake monitor: each accepted output must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t got, e;
        if (!reset && out_valid && out_ready) begin
            got = '{vec: out_vec, dst_we: out_dst_we, dst: out_dst,
                    s: {out_op3_s, out_op2_s, out_op1_s}, v: {out_op3_v, out_op2_v, out_op1_v}};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got dst=%0d s=%h", got.dst, got.s);
            end else begin
                e = q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL out_bundle got vec=%0b we=%0b dst=%0d s=%h v=%h exp vec=%0b we=%0b dst=%0d s=%h v=%h",
                             got.vec, got.dst_we, got.dst, got.s, got.v, e.vec, e.dst_we, e.dst, e.s, e.v);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic vec, input logic [2:0] use_, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                           input logic dwe, input logic [AW-1:0] dst);
        in_vec = vec; in_src_use = use_; in_a1 = a1; in_a2 = a2; in_a3 = a3;
        in_dst_we = dwe; in_dst = dst; in_valid = 1'b1;
    endtask

    // Independent model of the operand that should be captured for the currently presented instruction.
    task automatic push_exp();
        exp_t e;
        logic [AW-1:0] a [3];
        a[0] = in_a1; a[1] = in_a2; a[2] = in_a3;
        e = '0;
        e.vec = in_vec; e.dst_we = in_dst_we; e.dst = in_dst;
        for (int i = 0; i < 3; i++) begin
            if (in_src_use[i]) begin
                if (in_vec) e.v[i] = (wb_wre && wb_vec && wb_a3 == a[i]) ? wb_wd3_v : rf_v[a[i]];
                else        e.s[i] = (wb_wre && !wb_vec && wb_a3 == a[i]) ? wb_wd3_s : rf_s[a[i]];
            end
        end
        q.push_back(e);
    endtask

    task automatic expect_ready(input logic exp, input string name);
        checks++;
        if (in_ready !== exp) begin
            errors++;
            $display("FAIL %s in_ready got %0b exp %0b", name, in_ready, exp);
        end
    endtask

    // Present, require acceptance, queue the expectation and let it load on the next edge.
    task automatic issue_one(input logic vec, input logic [2:0] use_, input logic [AW-1:0] a1,
                             input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                             input logic dwe, input logic [AW-1:0] dst, input string name);
        present(vec, use_, a1, a2, a3, dwe, dst);
        #1;
        expect_ready(1'b1, name);
        push_exp();
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || out_dst !== '0 || out_op1_s !== '0 || out_op1_v !== '0 || stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got valid=%0b dst=%0d op1_s=%h stall=%0d exp all zero",
                     out_valid, out_dst, out_op1_s, stall_cycles);
        end
        expect_ready(1'b1, "reset_ready");
    endtask

    task automatic test_scalar_issue();
        issue_one(1'b0, 3'b011, 5'd1, 5'd2, 5'd0, 1'b0, 5'd0, "scalar_issue");
        checks++;
        if (out_valid !== 1'b1 || out_op1_s !== 16'h0005 || out_op2_s !== 16'h0007) begin
            errors++;
            $display("FAIL scalar_latency got valid=%0b op1=%h op2=%h exp 1 0005 0007",
                     out_valid, out_op1_s, out_op2_s);
        end
        issue_one(1'b0, 3'b111, 5'd9, 5'd10, 5'd11, 1'b0, 5'd0, "scalar_three_src");
    endtask

    task automatic test_raw();
        logic [15:0] sc0;
        issue_one(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, "raw_writer");
        present(1'b0, 3'b001, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0);
        #1;
        expect_ready(1'b0, "raw_stall");
        sc0 = stall_cycles;
        step();
        step();
        checks++;
        if (stall_cycles !== sc0 + 16'd2) begin
            errors++;
            $display("FAIL raw_stall_count got %0d exp %0d", stall_cycles, sc0 + 16'd2);
        end
        wb_wre = 1'b1; wb_vec = 1'b0; wb_a3 = 5'd3; wb_wd3_s = 16'h00AA;
        #1;
        expect_ready(1'b1, "raw_wb_release");
        push_exp();
        step();
        in_valid = 1'b0; wb_wre = 1'b0;
        issue_one(1'b0, 3'b001, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, "raw_busy_cleared");
    endtask

    task automatic test_waw();
        issue_one(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd8, "waw_writer");
        present(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd8);
        #1;
        expect_ready(1'b0, "waw_stall");
        step();
        wb_wre = 1'b1; wb_vec = 1'b0; wb_a3 = 5'd8; wb_wd3_s = 16'h1234;
        #1;
        expect_ready(1'b1, "waw_wb_release");
        push_exp();
        step();
        in_valid = 1'b0; wb_wre = 1'b0;
        // Issue set and writeback clear hit reg 8 on the same edge: it must remain busy.
        present(1'b0, 3'b001, 5'd8, 5'd0, 5'd0, 1'b0, 5'd0);
        #1;
        expect_ready(1'b0, "set_wins");
        in_valid = 1'b0;
        wb_wre = 1'b1; wb_a3 = 5'd8;
        step();
        wb_wre = 1'b0;
    endtask

    task automatic test_vec_bypass();
        wb_wre = 1'b1; wb_vec = 1'b1; wb_a3 = 5'd4; wb_wd3_v = 128'h1;
        issue_one(1'b1, 3'b001, 5'd4, 5'd0, 5'd0, 1'b0, 5'd0, "vec_bypass");
        wb_wre = 1'b0;
        checks++;
        if (out_op1_v !== 128'h1 || out_op1_s !== 16'h0) begin
            errors++;
            $display("FAIL vec_bypass_op got v=%h s=%h exp 1 0", out_op1_v, out_op1_s);
        end
        issue_one(1'b1, 3'b110, 5'd0, 5'd12, 5'd13, 1'b0, 5'd0, "vec_plain");
    endtask

    task automatic test_file_indep();
        issue_one(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, "indep_scalar_writer");
        issue_one(1'b1, 3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, "indep_vec_read");
        present(1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0);
        #1;
        expect_ready(1'b0, "indep_scalar_still_busy");
        in_valid = 1'b0;
        wb_wre = 1'b1; wb_vec = 1'b0; wb_a3 = 5'd5;
        step();
        wb_wre = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        issue_one(1'b0, 3'b001, 5'd6, 5'd0, 5'd0, 1'b1, 5'd20, "bp_first");
        present(1'b0, 3'b001, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            expect_ready(1'b0, "bp_hold_ready");
            checks++;
            if (out_valid !== 1'b1 || out_op1_s !== rf_s[6] || out_dst !== 5'd20 || out_dst_we !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_stable cyc %0d got valid=%0b op1=%h dst=%0d exp 1 %h 20",
                         k, out_valid, out_op1_s, out_dst, rf_s[6]);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        expect_ready(1'b1, "bp_release");
        push_exp();
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_op1_s !== rf_s[7]) begin
            errors++;
            $display("FAIL bp_next_load got valid=%0b op1=%h exp 1 %h", out_valid, out_op1_s, rf_s[7]);
        end
        step();
        wb_wre = 1'b1; wb_vec = 1'b0; wb_a3 = 5'd20;
        step();
        wb_wre = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        issue_one(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, "rst_writer");
        present(1'b0, 3'b001, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_dst !== '0 || out_dst_we !== 1'b0 || stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL rst_async got valid=%0b dst=%0d we=%0b stall=%0d exp 0 0 0 0",
                     out_valid, out_dst, out_dst_we, stall_cycles);
        end
        q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        step();
        out_ready = 1'b1;
        issue_one(1'b0, 3'b001, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, "rst_post_read");
    endtask

    initial begin
        in_valid = 0; in_vec = 0; in_src_use = 0; in_a1 = 0; in_a2 = 0; in_a3 = 0;
        in_dst_we = 0; in_dst = 0; wb_wre = 0; wb_vec = 0; wb_a3 = 0;
        wb_wd3_s = 0; wb_wd3_v = 0; out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rf_s[i] = 16'h0100 + 16'(i * 3);
            rf_v[i] = {4{32'hA000_0000 + 32'(i)}};
        end
        rf_s[1] = 16'h0005;
        rf_s[2] = 16'h0007;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        test_reset();
        step();
        test_scalar_issue();
        test_raw();
        test_waw();
        test_vec_bypass();
        test_file_indep();
        test_back_to_back();
        test_reset_mid();
        repeat (3) step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
